// File: rtl/corr_pkg.sv
// rtl/corr_pkg.sv - shared constants and state type for the lag-bank readout
package corr_pkg;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 32;
  localparam int LAGS    = 2 ** ADDR_W;
  localparam int GUARD   = LAGS + 3;
  localparam int GUARD_W = $clog2(GUARD + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, CLR_WAIT, INTEG, DRAIN_WAIT, READ} state_t;
endpackage

// File: rtl/corr_sync_fifo.sv
// rtl/corr_sync_fifo.sv - small synchronous FIFO with occupancy count
module corr_sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_wr_valid,
  input  logic [WIDTH-1:0]       i_wr_data,
  input  logic                   i_rd_ready,
  output logic                   o_rd_valid,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_rd_ready && (r_count != '0);
  assign w_push = i_wr_valid && ((r_count != (PTR_W+1)'(DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wr_data;
  end

  assign o_rd_valid = (r_count != '0);
  assign o_rd_data  = r_mem[r_rptr];
  assign o_count    = r_count;
endmodule

// File: rtl/corr_readout.sv
// rtl/corr_readout.sv - integration control, readout and clear of the lag MAC bank
module corr_readout
  import corr_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [CNT_W-1:0]  int_len,
  input  logic              sin_in,
  output logic              sin,
  output logic              clr,
  output logic              read,
  output logic [ADDR_W-1:0] rAddr,
  input  logic [DATA_W-1:0] rData,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_cnt
);
  localparam int FW   = DATA_W + ADDR_W + 1;
  localparam int FC_W = $clog2(FIFO_DEPTH) + 1;

  state_t             r_state;
  logic [GUARD_W-1:0] r_guard;
  logic               r_clr;
  logic               r_read;
  logic               r_lead;
  logic               r_issue_done;
  logic [ADDR_W-1:0]  r_raddr;
  logic               r_v1;
  logic               r_v2;
  logic [ADDR_W-1:0]  r_a1;
  logic [ADDR_W-1:0]  r_a2;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_drop;

  logic               w_guard_idle;
  logic               w_sin;
  logic               w_issue;
  logic               w_last_push;
  logic               w_head_valid;
  logic [FC_W-1:0]    w_fifo_cnt;
  logic [FC_W:0]      w_used;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [FW-1:0]      w_head;

  assign w_guard_idle = (r_guard == '0);
  assign w_sin        = sin_in && (r_state == INTEG) && w_guard_idle;
  assign w_cnt_nxt    = r_cnt + CNT_W'(1);
  assign w_used       = {1'b0, w_fifo_cnt} + {{FC_W{1'b0}}, r_v1} + {{FC_W{1'b0}}, r_v2};
  // Words still in the MAC read pipe count as occupied, so backpressure can never overflow the FIFO
  assign w_issue      = (r_state == READ) && !r_lead && !r_issue_done &&
                        (w_used < (FC_W+1)'(FIFO_DEPTH));
  assign w_last_push  = r_v2 && (r_a2 == ADDR_W'(LAGS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_guard <= '0;
      r_drop  <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_a1    <= '0;
      r_a2    <= '0;
    end else begin
      if (w_sin || r_clr)      r_guard <= GUARD_W'(GUARD);
      else if (!w_guard_idle)  r_guard <= r_guard - GUARD_W'(1);
      if (sin_in && run && !w_sin && (r_drop != '1)) r_drop <= r_drop + CNT_W'(1);
      r_v1 <= w_issue;
      r_a1 <= r_raddr;
      r_v2 <= r_v1;
      r_a2 <= r_a1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_clr        <= 1'b0;
      r_read       <= 1'b0;
      r_lead       <= 1'b0;
      r_issue_done <= 1'b0;
      r_raddr      <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        IDLE: if (run && w_guard_idle) r_state <= CLEAR;
        CLEAR: begin
          // First CLEAR cycle is the read-to-clear turnaround; the second carries the pulse
          if (!r_clr) begin
            r_clr <= 1'b1;
          end else begin
            r_clr   <= 1'b0;
            r_state <= CLR_WAIT;
          end
        end
        CLR_WAIT: if (w_guard_idle) begin
          if (run) begin
            r_len   <= (int_len == '0) ? CNT_W'(1) : int_len;
            r_cnt   <= '0;
            r_state <= INTEG;
          end else begin
            r_state <= IDLE;
          end
        end
        INTEG: if (w_sin) begin
          r_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == r_len) r_state <= DRAIN_WAIT;
        end
        DRAIN_WAIT: if (w_guard_idle) begin
          r_state      <= READ;
          r_read       <= 1'b1;
          r_lead       <= 1'b1;
          r_issue_done <= 1'b0;
          r_raddr      <= '0;
        end
        READ: begin
          r_lead <= 1'b0;
          if (w_issue) begin
            if (r_raddr == ADDR_W'(LAGS - 1)) r_issue_done <= 1'b1;
            else                              r_raddr      <= r_raddr + ADDR_W'(1);
          end
          if (w_last_push) begin
            r_read  <= 1'b0;
            r_state <= CLEAR;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  corr_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_valid (r_v2),
    .i_wr_data  ({rData, r_a2, w_last_push}),
    .i_rd_ready (out_ready),
    .o_rd_valid (w_head_valid),
    .o_rd_data  (w_head),
    .o_count    (w_fifo_cnt)
  );

  assign sin       = w_sin;
  assign clr       = r_clr;
  assign read      = r_read;
  assign rAddr     = r_raddr;
  assign busy      = (r_state != IDLE);
  assign drop_cnt  = r_drop;
  assign out_valid = w_head_valid;
  assign {out_data, out_addr, out_last} = w_head_valid ? w_head : '0;
endmodule
